// File: rtl/gen_fip_matvec_ctrl.sv
// Matrix-vector sequencer for gen_fip_inner_prod.
// Fetches one matrix row at a time and hands it to the inner-product engine
// with a constant operand vector. Each engine result is forwarded with its
// row index. A done pulse ends the job, and a sticky error flag reports
// oversize jobs and timeouts.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | no job; waiting for i_start_pls
// RD_REQ   | one-cycle row read request for the current row
// RD_WAIT  | waiting for row data from memory (bounded by TIMEOUT_CYC)
// IP_ISSUE | one-cycle valid pulse to the engine with captured operands
// IP_WAIT  | waiting for the engine result (bounded by TIMEOUT_CYC)
//
// Every output is registered. The output comb process computes each
// register's next value from the current state and the next state, so
// pulses line up with state entry without any input-to-output comb path.
// SIM_DLY is kept for compatibility with the engine's parameter set. This
// RTL uses zero-delay register updates, so SIM_DLY is only range-checked.
module gen_fip_matvec_ctrl #(
    parameter int VEC_ELEMS_NUM = 32,
    parameter int ONE_ELEM_W    = 6,
    parameter int RES_W         = 14,
    parameter int ROWS_NUM      = 16,
    parameter int ROW_W         = 4,
    parameter int TIMEOUT_CYC   = 64,
    parameter int SIM_DLY       = 1
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic                                sw_rst,
    input  logic                                i_start_pls,
    input  logic [ROW_W:0]                      i_rows_num,
    input  logic [ONE_ELEM_W*VEC_ELEMS_NUM-1:0] i_vec,
    output logic                                o_row_rd_req,
    output logic [ROW_W-1:0]                    o_row_rd_addr,
    input  logic                                i_row_rd_valid,
    input  logic [ONE_ELEM_W*VEC_ELEMS_NUM-1:0] i_row_rd_data,
    output logic                                o_ip_valid_pls,
    output logic [ONE_ELEM_W*VEC_ELEMS_NUM-1:0] o_ip_vec1,
    output logic [ONE_ELEM_W*VEC_ELEMS_NUM-1:0] o_ip_vec2,
    input  logic                                i_ip_valid_pls,
    input  logic [RES_W-1:0]                    i_ip_res,
    output logic                                o_res_valid_pls,
    output logic [ROW_W-1:0]                    o_res_idx,
    output logic [RES_W-1:0]                    o_res,
    output logic                                o_busy,
    output logic                                o_done_pls,
    output logic                                o_err
);

    localparam int VEC_W = ONE_ELEM_W * VEC_ELEMS_NUM;
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [ROW_W:0]   ROWS_LIM = (ROW_W + 1)'(ROWS_NUM);
    localparam logic [TMO_W-1:0] TMO_LIM  = TMO_W'(TIMEOUT_CYC);

    if (ROW_W != $clog2(ROWS_NUM)) begin : g_bad_row_w
        $error("ROW_W must equal clog2(ROWS_NUM)");
    end
    if ((VEC_ELEMS_NUM & (VEC_ELEMS_NUM - 1)) != 0) begin : g_bad_elems
        $error("VEC_ELEMS_NUM must be a power of 2");
    end
    if (SIM_DLY < 0) begin : g_bad_dly
        $error("SIM_DLY must be non-negative");
    end

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_REQ   = 3'd1,
        RD_WAIT  = 3'd2,
        IP_ISSUE = 3'd3,
        IP_WAIT  = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [ROW_W-1:0] row_cnt, row_cnt_nxt;
    logic [ROW_W:0]   rows_q, rows_q_nxt;
    logic [TMO_W-1:0] tmo_cnt, tmo_cnt_nxt, tmo_inc;

    logic             rd_req_nxt, ip_valid_nxt, res_valid_nxt;
    logic             busy_nxt, done_nxt, err_nxt;
    logic [ROW_W-1:0] rd_addr_nxt, res_idx_nxt;
    logic [RES_W-1:0] res_nxt;
    logic [VEC_W-1:0] vec1_nxt, vec2_nxt;

    logic start_acc, rows_zero, rows_over, tmo_hit, last_row;

    assign start_acc = (state == IDLE) && i_start_pls;
    assign rows_zero = (i_rows_num == '0);
    assign rows_over = (i_rows_num > ROWS_LIM);
    assign tmo_inc   = tmo_cnt + TMO_W'(1);
    assign tmo_hit   = (tmo_inc == TMO_LIM);
    assign last_row  = ({1'b0, row_cnt} == (rows_q - (ROW_W + 1)'(1)));

    // State register; soft reset acts exactly like the async reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else if (sw_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a valid pulse wins over a timeout on the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_acc && !rows_zero && !rows_over) begin
                    state_nxt = RD_REQ;
                end
            end
            RD_REQ:   state_nxt = RD_WAIT;
            RD_WAIT: begin
                if (i_row_rd_valid) begin
                    state_nxt = IP_ISSUE;
                end else if (tmo_hit) begin
                    state_nxt = IDLE;
                end
            end
            IP_ISSUE: state_nxt = IP_WAIT;
            IP_WAIT: begin
                if (i_ip_valid_pls) begin
                    state_nxt = last_row ? IDLE : RD_REQ;
                end else if (tmo_hit) begin
                    state_nxt = IDLE;
                end
            end
            default:  state_nxt = IDLE;
        endcase
    end

    // Next values for every registered output and datapath register.
    always_comb begin
        rd_req_nxt    = (state_nxt == RD_REQ);
        ip_valid_nxt  = (state_nxt == IP_ISSUE);
        busy_nxt      = (state_nxt != IDLE);
        res_valid_nxt = 1'b0;
        done_nxt      = 1'b0;
        err_nxt       = o_err;
        res_nxt       = o_res;
        res_idx_nxt   = o_res_idx;
        vec1_nxt      = o_ip_vec1;
        vec2_nxt      = o_ip_vec2;
        row_cnt_nxt   = row_cnt;
        rows_q_nxt    = rows_q;
        tmo_cnt_nxt   = '0;
        case (state)
            IDLE: begin
                if (start_acc) begin
                    vec2_nxt    = i_vec;
                    row_cnt_nxt = '0;
                    rows_q_nxt  = i_rows_num;
                    err_nxt     = rows_over;
                    done_nxt    = rows_zero || rows_over;
                end
            end
            RD_WAIT: begin
                tmo_cnt_nxt = tmo_inc;
                if (i_row_rd_valid) begin
                    vec1_nxt = i_row_rd_data;
                end else if (tmo_hit) begin
                    err_nxt  = 1'b1;
                    done_nxt = 1'b1;
                end
            end
            IP_WAIT: begin
                tmo_cnt_nxt = tmo_inc;
                if (i_ip_valid_pls) begin
                    res_valid_nxt = 1'b1;
                    res_nxt       = i_ip_res;
                    res_idx_nxt   = row_cnt;
                    if (last_row) begin
                        done_nxt = 1'b1;
                    end else begin
                        row_cnt_nxt = row_cnt + ROW_W'(1);
                    end
                end else if (tmo_hit) begin
                    err_nxt  = 1'b1;
                    done_nxt = 1'b1;
                end
            end
            default: ;
        endcase
        rd_addr_nxt = row_cnt_nxt;
    end

    // Output and datapath registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_row_rd_req    <= 1'b0;
            o_row_rd_addr   <= '0;
            o_ip_valid_pls  <= 1'b0;
            o_ip_vec1       <= '0;
            o_ip_vec2       <= '0;
            o_res_valid_pls <= 1'b0;
            o_res_idx       <= '0;
            o_res           <= '0;
            o_busy          <= 1'b0;
            o_done_pls      <= 1'b0;
            o_err           <= 1'b0;
            row_cnt         <= '0;
            rows_q          <= '0;
            tmo_cnt         <= '0;
        end else if (sw_rst) begin
            o_row_rd_req    <= 1'b0;
            o_row_rd_addr   <= '0;
            o_ip_valid_pls  <= 1'b0;
            o_ip_vec1       <= '0;
            o_ip_vec2       <= '0;
            o_res_valid_pls <= 1'b0;
            o_res_idx       <= '0;
            o_res           <= '0;
            o_busy          <= 1'b0;
            o_done_pls      <= 1'b0;
            o_err           <= 1'b0;
            row_cnt         <= '0;
            rows_q          <= '0;
            tmo_cnt         <= '0;
        end else begin
            o_row_rd_req    <= rd_req_nxt;
            o_row_rd_addr   <= rd_addr_nxt;
            o_ip_valid_pls  <= ip_valid_nxt;
            o_ip_vec1       <= vec1_nxt;
            o_ip_vec2       <= vec2_nxt;
            o_res_valid_pls <= res_valid_nxt;
            o_res_idx       <= res_idx_nxt;
            o_res           <= res_nxt;
            o_busy          <= busy_nxt;
            o_done_pls      <= done_nxt;
            o_err           <= err_nxt;
            row_cnt         <= row_cnt_nxt;
            rows_q          <= rows_q_nxt;
            tmo_cnt         <= tmo_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_gen_fip_matvec_ctrl.sv
// Scoreboard bench for gen_fip_matvec_ctrl.
// The driver acts as row memory and engine. It pushes the response each
// stimulus should cause, and a separate monitor pops and compares whenever
// the DUT pulses an output.
module tb_gen_fip_matvec_ctrl;

    localparam int VEC_ELEMS_NUM = 32;
    localparam int ONE_ELEM_W    = 6;
    localparam int RES_W         = 14;
    localparam int ROWS_NUM      = 16;
    localparam int ROW_W         = 4;
    localparam int TIMEOUT_CYC   = 64;
    localparam int VEC_W         = VEC_ELEMS_NUM * ONE_ELEM_W;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic               sw_rst = 1'b0;
    logic               i_start_pls = 1'b0;
    logic [ROW_W:0]     i_rows_num = '0;
    logic [VEC_W-1:0]   i_vec = '0;
    logic               o_row_rd_req;
    logic [ROW_W-1:0]   o_row_rd_addr;
    logic               i_row_rd_valid = 1'b0;
    logic [VEC_W-1:0]   i_row_rd_data = '0;
    logic               o_ip_valid_pls;
    logic [VEC_W-1:0]   o_ip_vec1;
    logic [VEC_W-1:0]   o_ip_vec2;
    logic               i_ip_valid_pls = 1'b0;
    logic [RES_W-1:0]   i_ip_res = '0;
    logic               o_res_valid_pls;
    logic [ROW_W-1:0]   o_res_idx;
    logic [RES_W-1:0]   o_res;
    logic               o_busy;
    logic               o_done_pls;
    logic               o_err;

    gen_fip_matvec_ctrl #(
        .VEC_ELEMS_NUM(VEC_ELEMS_NUM), .ONE_ELEM_W(ONE_ELEM_W), .RES_W(RES_W),
        .ROWS_NUM(ROWS_NUM), .ROW_W(ROW_W), .TIMEOUT_CYC(TIMEOUT_CYC), .SIM_DLY(1)
    ) dut (
        .clk(clk), .rstn(rstn), .sw_rst(sw_rst), .i_start_pls(i_start_pls),
        .i_rows_num(i_rows_num), .i_vec(i_vec), .o_row_rd_req(o_row_rd_req),
        .o_row_rd_addr(o_row_rd_addr), .i_row_rd_valid(i_row_rd_valid),
        .i_row_rd_data(i_row_rd_data), .o_ip_valid_pls(o_ip_valid_pls),
        .o_ip_vec1(o_ip_vec1), .o_ip_vec2(o_ip_vec2), .i_ip_valid_pls(i_ip_valid_pls),
        .i_ip_res(i_ip_res), .o_res_valid_pls(o_res_valid_pls), .o_res_idx(o_res_idx),
        .o_res(o_res), .o_busy(o_busy), .o_done_pls(o_done_pls), .o_err(o_err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [ROW_W-1:0] idx; logic [RES_W-1:0] res; } res_t;
    typedef struct { logic err; logic with_res; } done_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned exp_addr_q[$];
    logic [VEC_W-1:0] exp_vec1_q[$];
    res_t        exp_res_q[$];
    done_t       exp_done_q[$];
    logic [VEC_W-1:0] exp_vec2 = '0;

    // Per-job stimulus tables
    logic [VEC_W-1:0] mem [ROWS_NUM];
    logic [RES_W-1:0] res_val [ROWS_NUM];
    int               rd_lat [ROWS_NUM];
    int               ip_lat [ROWS_NUM];
    logic [VEC_W-1:0] job_vec;

    task automatic check(input string name, input logic [VEC_W-1:0] act, input logic [VEC_W-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [VEC_W-1:0] rand_vec();
        logic [VEC_W-1:0] v;
        for (int i = 0; i < VEC_W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic push_res(input int idx, input logic [RES_W-1:0] r);
        res_t e;
        e.idx = ROW_W'(idx);
        e.res = r;
        exp_res_q.push_back(e);
    endtask

    task automatic push_done(input logic err, input logic with_res);
        done_t e;
        e.err = err;
        e.with_res = with_res;
        exp_done_q.push_back(e);
    endtask

    // Monitor: every output pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (o_row_rd_req) begin
            if (exp_addr_q.size() == 0) check("unexpected_rd_req", 1, 0);
            else check("rd_addr", o_row_rd_addr, exp_addr_q.pop_front());
        end
        if (o_ip_valid_pls) begin
            if (exp_vec1_q.size() == 0) check("unexpected_ip_valid", 1, 0);
            else check("ip_vec1", o_ip_vec1, exp_vec1_q.pop_front());
            check("ip_vec2", o_ip_vec2, exp_vec2);
        end
        if (o_res_valid_pls) begin
            if (exp_res_q.size() == 0) check("unexpected_res_valid", 1, 0);
            else begin
                res_t e;
                e = exp_res_q.pop_front();
                check("res_idx", o_res_idx, e.idx);
                check("res_value", o_res, e.res);
            end
        end
        if (o_done_pls) begin
            if (exp_done_q.size() == 0) check("unexpected_done", 1, 0);
            else begin
                done_t d;
                d = exp_done_q.pop_front();
                check("done_err", o_err, d.err);
                check("done_with_res", o_res_valid_pls, d.with_res);
                check("done_busy_low", o_busy, 0);
            end
        end
    end

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (o_row_rd_req) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("rd_req_wait_expired", 0, 1);
    endtask

    // Counts falling edges from the last request/issue pulse to done.
    // Entry into the wait state is one cycle after that pulse, so the
    // expected distance is TIMEOUT_CYC+1.
    task automatic wait_timeout_done();
        int k;
        k = 0;
        while (k < 200 && !o_done_pls) begin
            @(negedge clk);
            k++;
        end
        check("timeout_cycles", k, TIMEOUT_CYC + 1);
        check("timeout_err", o_err, 1);
    endtask

    task automatic rand_setup(input int rows);
        job_vec = rand_vec();
        for (int r = 0; r < ROWS_NUM; r++) begin
            mem[r]     = rand_vec();
            res_val[r] = RES_W'($urandom);
            rd_lat[r]  = $urandom_range(1, 6);
            ip_lat[r]  = $urandom_range(1, 6);
        end
        if (rows < 0) job_vec = '0;
    endtask

    // kind: 0 normal, 1 memory silent, 2 engine silent, 3 sw_rst, 4 rstn
    // (kinds 1..4 act on row at_row)
    task automatic run_job(input int rows, input int at_row, input int kind, input bit poke);
        bit ok;
        bit bad;
        bad = (rows == 0) || (rows > ROWS_NUM);
        @(negedge clk);
        i_start_pls = 1'b1;
        i_rows_num  = (ROW_W + 1)'(rows);
        i_vec       = job_vec;
        if (bad) push_done(rows > ROWS_NUM, 1'b0);
        else begin
            exp_vec2 = job_vec;
            exp_addr_q.push_back(0);
        end
        @(negedge clk);
        i_start_pls = 1'b0;
        i_rows_num  = (ROW_W + 1)'($urandom);
        i_vec       = rand_vec();
        if (bad) begin
            check("bad_start_done", o_done_pls, 1);
            check("bad_start_busy", o_busy, 0);
            check("bad_start_no_rd", o_row_rd_req, 0);
            return;
        end
        check("start_busy", o_busy, 1);
        check("start_rd_req", o_row_rd_req, 1);
        check("start_err_clear", o_err, 0);
        for (int r = 0; r < rows; r++) begin
            wait_req(ok);
            if (!ok) return;
            if (kind == 1 && r == at_row) begin
                push_done(1'b1, 1'b0);
                wait_timeout_done();
                return;
            end
            if (poke && r == 0) begin
                i_start_pls = 1'b1;
                i_rows_num  = '0;
                i_vec       = ~job_vec;
            end
            for (int d = 0; d < rd_lat[r]; d++) begin
                @(negedge clk);
                i_start_pls = 1'b0;
            end
            exp_vec1_q.push_back(mem[r]);
            i_row_rd_valid = 1'b1;
            i_row_rd_data  = mem[r];
            @(negedge clk);
            i_row_rd_valid = 1'b0;
            i_row_rd_data  = rand_vec();
            check("ip_issue_latency", o_ip_valid_pls, 1);
            if (kind == 2 && r == at_row) begin
                push_done(1'b1, 1'b0);
                wait_timeout_done();
                return;
            end
            if (kind >= 3 && r == at_row) begin
                repeat (2) @(negedge clk);
                if (kind == 3) sw_rst = 1'b1;
                else rstn = 1'b0;
                @(negedge clk);
                check("rst_vecs_zero", o_ip_vec1 | o_ip_vec2, 0);
                check("rst_ctrl_zero", {o_row_rd_req, o_row_rd_addr, o_ip_valid_pls, o_res_valid_pls,
                                        o_res_idx, o_res, o_busy, o_done_pls, o_err}, 0);
                sw_rst = 1'b0;
                rstn   = 1'b1;
                i_ip_valid_pls = 1'b1;
                i_ip_res       = RES_W'($urandom);
                @(negedge clk);
                i_ip_valid_pls = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("rst_quiet", {o_res_valid_pls, o_done_pls, o_busy}, 0);
                end
                return;
            end
            for (int d = 0; d < ip_lat[r]; d++) @(negedge clk);
            push_res(r, res_val[r]);
            if (r == rows - 1) push_done(1'b0, 1'b1);
            else exp_addr_q.push_back(r + 1);
            i_ip_valid_pls = 1'b1;
            i_ip_res       = res_val[r];
            @(negedge clk);
            i_ip_valid_pls = 1'b0;
            i_ip_res       = RES_W'($urandom);
            check("res_latency", o_res_valid_pls, 1);
        end
        check("end_busy_low", o_busy, 0);
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_ctrl", {o_row_rd_req, o_row_rd_addr, o_ip_valid_pls, o_res_valid_pls,
                             o_res_idx, o_res, o_busy, o_done_pls, o_err}, 0);
        check("reset_vecs", o_ip_vec1 | o_ip_vec2, 0);
        rstn = 1'b1;
        @(negedge clk);
        check("post_reset_idle", {o_busy, o_done_pls, o_row_rd_req}, 0);

        // Basic path: Q1.5 0.96875 in elements 0..3 of both operands
        rand_setup(1);
        job_vec = '0;
        job_vec[4*ONE_ELEM_W-1:0] = {4{6'b011111}};
        mem[0] = job_vec;
        res_val[0] = 14'd3844;
        run_job(1, 0, 0, 1'b0);

        // Multi-row with a saturated last result
        rand_setup(3);
        res_val[0] = 14'd198;
        res_val[1] = 14'd4096;
        res_val[2] = 14'd8191;
        run_job(3, 0, 0, 1'b0);

        // Variable latency; a start pulse while busy must be ignored
        rand_setup(2);
        rd_lat[0] = 1;
        rd_lat[1] = 10;
        ip_lat[0] = 3;
        ip_lat[1] = 7;
        run_job(2, 0, 0, 1'b1);

        // Boundaries
        rand_setup(0);
        run_job(0, 0, 0, 1'b0);
        run_job(17, 0, 0, 1'b0);
        run_job(0, 0, 0, 1'b0);
        rand_setup(16);
        run_job(16, 0, 0, 1'b1);

        // Timeouts, each followed by a clean job that must clear o_err
        rand_setup(3);
        run_job(3, 1, 2, 1'b0);
        rand_setup(2);
        run_job(2, 0, 0, 1'b0);
        rand_setup(2);
        run_job(2, 0, 1, 1'b0);
        rand_setup(1);
        run_job(1, 0, 0, 1'b0);

        // Resets in the middle of a job
        rand_setup(3);
        run_job(3, 1, 3, 1'b0);
        rand_setup(3);
        run_job(3, 1, 4, 1'b0);
        rand_setup(2);
        run_job(2, 0, 0, 1'b0);

        // Randomized jobs
        for (int j = 0; j < 10; j++) begin
            int rows;
            rows = $urandom_range(1, ROWS_NUM);
            rand_setup(rows);
            run_job(rows, 0, 0, ($urandom_range(0, 1) == 1));
        end

        repeat (4) @(negedge clk);
        check("left_addr", exp_addr_q.size(), 0);
        check("left_vec1", exp_vec1_q.size(), 0);
        check("left_res", exp_res_q.size(), 0);
        check("left_done", exp_done_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
